// File: rtl/ps2_kb_pkg.sv
// Shared scan codes, status-word field positions and receiver FSM states for the PS/2 keyboard decoder.
package ps2_kb_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam int KB_UP       = 0;
  localparam int KB_DOWN     = 1;
  localparam int KB_LEFT     = 2;
  localparam int KB_RIGHT    = 3;
  localparam int KB_ENTER    = 4;
  localparam int KB_CODE_LSB = 8;
  localparam int KB_EXT      = 16;
  localparam int KB_CNT_LSB  = 24;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  // One-hot held-key bit for a tracked key, zero for anything untracked.
  function automatic logic [4:0] held_mask(input logic ext, input logic [7:0] code);
    held_mask = '0;
    if (ext) begin
      case (code)
        SC_UP:    held_mask[KB_UP]    = 1'b1;
        SC_DOWN:  held_mask[KB_DOWN]  = 1'b1;
        SC_LEFT:  held_mask[KB_LEFT]  = 1'b1;
        SC_RIGHT: held_mask[KB_RIGHT] = 1'b1;
        default:  held_mask = '0;
      endcase
    end else if (code == SC_ENTER) begin
      held_mask[KB_ENTER] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, frame FSM, timeout and stop/parity checks.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx
  import ps2_kb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  ps2_state_e    r_state;
  ps2_state_e    w_next;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tmo;
  logic          w_fall;
  logic          w_bit;
  logic          w_timeout;
  logic          w_par_ok;
  logic          w_stop_edge;

  assign w_fall      = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_bit       = r_dat_sync[1];
  assign w_timeout   = (r_state != IDLE) && !w_fall && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_stop_edge = (r_state == STOP) && w_fall;
  assign o_byte      = r_shift;

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  // Synchronizers idle high so reset release never produces a phantom edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_fall && !w_bit)              w_next = DATA;
      DATA:    if (w_fall && (r_bitcnt == 3'd7))  w_next = PARITY;
      PARITY:  if (w_fall)                        w_next = STOP;
      STOP:    if (w_fall)                        w_next = IDLE;
      default:                                    w_next = IDLE;
    endcase
    if (w_timeout) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitcnt     <= '0;
      r_tmo        <= '0;
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      if (r_state == IDLE)                r_bitcnt <= '0;
      else if (r_state == DATA && w_fall) r_bitcnt <= r_bitcnt + 3'd1;
      if (r_state == IDLE || w_fall) r_tmo <= '0;
      else                           r_tmo <= r_tmo + TW'(1);
      o_byte_valid <= w_stop_edge && w_bit && w_par_ok;
      o_err        <= w_timeout || (w_stop_edge && !(w_bit && w_par_ok));
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == DATA && w_fall)   r_shift <= {w_bit, r_shift[7:1]};
    if (r_state == PARITY && w_fall) r_par   <= w_bit;
  end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard decoder: E0/F0 prefix tracking, held arrow/Enter bits, last make code and event count.
// Parity checking in the frame receiver is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keyboard_decoder
  import ps2_kb_pkg::*;
#(
  parameter int bus            = 32,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  output logic [bus-1:0] keyboard_data,
  output logic           frame_err
);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_err;
  logic [4:0] w_mask;
  logic [4:0] r_held;
  logic [7:0] r_last_code;
  logic       r_last_ext;
  logic [7:0] r_cnt;
  logic       r_ext;
  logic       r_brk;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_err        (w_err)
  );

  assign w_mask    = held_mask(r_ext, w_byte);
  assign frame_err = w_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_held      <= '0;
      r_last_code <= '0;
      r_last_ext  <= 1'b0;
      r_cnt       <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
    end else if (w_byte_valid) begin
      if (w_byte == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (w_byte == SC_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        r_held <= r_brk ? (r_held & ~w_mask) : (r_held | w_mask);
        // Typematic repeats count as fresh makes.
        if (!r_brk) begin
          r_last_code <= w_byte;
          r_last_ext  <= r_ext;
          r_cnt       <= r_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    keyboard_data = '0;
    keyboard_data[KB_ENTER:KB_UP]            = r_held;
    keyboard_data[KB_CODE_LSB +: 8]          = r_last_code;
    keyboard_data[KB_EXT]                    = r_last_ext;
    keyboard_data[KB_CNT_LSB +: 8]           = r_cnt;
  end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Randomized self-checking bench for ps2_keyboard_decoder against a scan-code-level reference model.
module tb_ps2_keyboard_decoder;

  localparam int TMO  = 200;
  localparam int HALF = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keyboard_data;
  logic        frame_err;

  int n_chk = 0;
  int n_fail = 0;
  int err_seen = 0;

  logic [4:0] m_held;
  logic [7:0] m_code;
  logic [7:0] m_cnt;
  logic       m_lext;
  logic       m_ext;
  logic       m_brk;

  always #5 clk = ~clk;

  ps2_keyboard_decoder #(.bus(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .keyboard_data (keyboard_data),
    .frame_err     (frame_err)
  );

  always @(posedge clk) if (frame_err === 1'b1) err_seen <= err_seen + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_word();
    return {m_cnt, 7'd0, m_lext, m_code, 3'd0, m_held};
  endfunction

  task automatic model_reset();
    m_held = '0; m_code = '0; m_cnt = '0; m_lext = 0; m_ext = 0; m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    k = -1;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (m_ext) begin
        if (b == 8'h75) k = 0;
        if (b == 8'h72) k = 1;
        if (b == 8'h6B) k = 2;
        if (b == 8'h74) k = 3;
      end else if (b == 8'h5A) k = 4;
      if (k >= 0) m_held[k] = !m_brk;
      if (!m_brk) begin
        m_code = b;
        m_lext = m_ext;
        m_cnt  = m_cnt + 8'd1;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(!bad_stop);
    ps2_data = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] b, input logic bad_par,
                           input logic bad_stop);
    int   e0;
    logic discard;
    e0 = err_seen;
`ifdef PS2_PARITY_CHECK_EN
    discard = bad_stop || bad_par;
`else
    discard = bad_stop;
`endif
    send_frame(b, bad_par, bad_stop);
    if (!discard) model_byte(b);
    check_eq({tag, "_kd"}, keyboard_data, m_word());
    check_eq({tag, "_err"}, 32'(err_seen - e0), 32'(discard));
  endtask

  logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h1C};

  initial begin
    int         e0;
    logic [31:0] kd0;
    logic [7:0] b;
    model_reset();
    repeat (4) @(negedge clk);
    check_eq("rst_kd", keyboard_data, 32'h0);
    check_eq("rst_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    frame_chk("t1", 8'h5A, 0, 0);
    check_eq("t1_word", keyboard_data, 32'h01005A10);

    frame_chk("t2_e0", 8'hE0, 0, 0);
    frame_chk("t2_75", 8'h75, 0, 0);
    check_eq("t2_make", keyboard_data, 32'h02017511);
    frame_chk("t2_be0", 8'hE0, 0, 0);
    frame_chk("t2_bf0", 8'hF0, 0, 0);
    frame_chk("t2_b75", 8'h75, 0, 0);
    check_eq("t2_break", keyboard_data, 32'h02017510);

    for (int i = 0; i < 256; i++) frame_chk("t3", 8'h1C, 0, 0);
    check_eq("t3_wrap", keyboard_data, 32'h02001C10);

    e0  = err_seen;
    kd0 = keyboard_data;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 10) @(negedge clk);
    check_eq("t4_err", 32'(err_seen - e0), 32'd1);
    check_eq("t4_kd", keyboard_data, kd0);
    frame_chk("t4_e0", 8'hE0, 0, 0);
    frame_chk("t4_6b", 8'h6B, 0, 0);

    frame_chk("t5_stop", 8'h72, 0, 1);
    frame_chk("t5_par", 8'h29, 1, 0);

    for (int i = 0; i < 120; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      frame_chk("rnd", b, 0, ($urandom_range(0, 15) == 0));
    end

    frame_chk("t6_e0", 8'hE0, 0, 0);
    frame_chk("t6_75", 8'h75, 0, 0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_async_kd", keyboard_data, 32'h0);
    check_eq("t6_async_err", 32'(frame_err), 32'h0);
    model_reset();
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    frame_chk("t6_5a", 8'h5A, 0, 0);
    check_eq("t6_word", keyboard_data, 32'h01005A10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
